sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Round-robin arbiter sharing one SRAM bank interface among NUM_PORTS word-level requesters, for example the AXI SRAM wrapper datapath and a DMA or scrub engine. It grants one request per cycle and registers the winning request onto the bank pins. Each read is tracked through the fixed SRAM read latency so that read data returns only to the port that issued it. A per-port lock keeps burst beats from one requester contiguous on the bank.

## Interface
- NUM_PORTS, 2, number of requester ports (≥2)
- ADDR_WIDTH, 16, bank word address width
- DATA_WIDTH, 32, bank data width (multiple of 8)
- SRAM_READ_LATENCY, 2, cycles from registered cs to valid sram_rdata_i (≥1)
- LOCK_TIMEOUT, 4, idle owner cycles before a held lock is force-released (≥1)
- STARVE_LIMIT, 16, wait cycles that trigger preemption (used only with SRAM_ARB_STARVE_EN)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is synchronous and active-low
- req_i  in  NUM_PORTS  per-port request
- we_i  in  NUM_PORTS  per-port write enable (1 = write)
- lock_i  in  NUM_PORTS  hold grant after this beat
- addr_i  in  NUM_PORTS×ADDR_WIDTH  per-port word address
- be_i  in  NUM_PORTS×DATA_WIDTH/8  per-port byte enables
- wdata_i  in  NUM_PORTS×DATA_WIDTH  per-port write data
- gnt_o  out  NUM_PORTS  one-hot grant, combinational, same cycle as req_i
- rvalid_o  out  NUM_PORTS  one-hot read-data valid
- rdata_o  out  DATA_WIDTH  read data (sram_rdata_i, unregistered)
- sram_cs_o  out  1  registered chip select
- sram_we_o  out  1  registered write enable
- sram_addr_o  out  ADDR_WIDTH  registered address
- sram_be_o  out  DATA_WIDTH/8  registered byte enables
- sram_wdata_o  out  DATA_WIDTH  registered write data
- sram_rdata_i  in  DATA_WIDTH  bank read data

## Operation
- State machine with two states: ARB and LOCKED(owner).
- ARB state:
  - Scan req_i starting at rr_ptr; grant the first requester found.
  - rr_ptr ← (granted+1) mod NUM_PORTS.
  - If the granted beat has lock_i=1: go to LOCKED with owner = granted port.
- LOCKED state:
  - Only the owner can be granted. Other ports see gnt_o=0.
  - Owner granted beat with lock_i=0: return to ARB. rr_ptr advances past the owner.
  - Owner req_i=0: the idle counter increments. At LOCK_TIMEOUT consecutive idle cycles, return to ARB in the next cycle. The counter clears on every owner grant.
- A granted request is a transaction. On the next edge:
  - sram_cs_o=1.
  - we, addr, be, wdata are copied from the winning port.
- With no grant: sram_cs_o=0 and the other sram_* outputs hold their previous values.
- Read tracking: a shift pipe of depth SRAM_READ_LATENCY+1 carries (valid, owner index) for each granted read. Writes insert no valid entry.
- rvalid_o[owner] = pipe tail valid. Write beats generate no response.
- No backpressure exists on read return: requesters must accept rvalid_o unconditionally.

## Timing
- Grant at cycle T → bank access at T+1 → rvalid_o/rdata_o at T+1+SRAM_READ_LATENCY.
- Throughput is one beat per cycle, with no bubble between ports or between read and write.
- Reset values:
  - sram_cs_o, sram_we_o = 0; sram_addr_o, sram_be_o, sram_wdata_o = 0.
  - rvalid_o = 0; gnt_o = 0 while rst_ni=0.
  - State = ARB, rr_ptr = 0, pipe cleared, counters = 0.
- Reset mid-operation: all in-flight reads are discarded and no rvalid_o is asserted for them. A lock is not retained across reset.
- All requesters idle: gnt_o=0, sram_cs_o=0 next cycle, rr_ptr unchanged.
- Lock request while already LOCKED by the same port: the state stays LOCKED.
- Pointer wrap: rr_ptr = NUM_PORTS-1 wraps to 0.

## Configuration
- SRAM_ARB_STARVE_EN defined:
  - Each port has a wait counter. It increments each cycle req_i=1 and gnt_o=0, and clears on grant.
  - When any counter reaches STARVE_LIMIT in LOCKED, the lock is released after the current cycle's owner beat, if any.
  - In the following ARB cycle, the starved port is granted ahead of rr_ptr. The lowest index wins if several ports are starved.
- Undefined: no counters exist. A lock is released only by the owner (lock_i=0) or by LOCK_TIMEOUT.

## Test plan
- Ports 0 and 1 request reads continuously, NUM_PORTS=2 → grants alternate 0,1,0,1. Each rvalid_o arrives exactly 3 cycles after its grant (latency 2), to the correct port.
- Port 1 writes addr 0x0010 be=0xF data=0xDEADBEEF at T; port 0 reads 0x0010 at T+1 → sram_we_o=1 at T+1. Port 0 rvalid at T+4 with rdata_o=0xDEADBEEF (behavioural bank model).
- Port 0 issues 4 beats with lock_i=1,1,1,0 while port 1 requests throughout → port 1 is first granted on the cycle after port 0's 4th beat.
- Port 0 locks, then drops req_i → with LOCK_TIMEOUT=4, port 1 is granted in the 5th cycle after the drop.
- Assert rst_ni=0 for 1 cycle while 2 reads are in flight → no rvalid_o for those reads; all sram_* outputs are 0 after the reset edge.
- With SRAM_ARB_STARVE_EN and STARVE_LIMIT=16, port 0 holds lock indefinitely while port 1 requests → port 1 is granted at 17 cycles of waiting.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Round-robin arbiter that shares one SRAM bank among NUM_PORTS word-level
//   requesters. One request is granted per cycle and registered onto the bank
//   pins. Reads are tracked through the fixed bank latency so that read data
//   returns only to the issuing port. A per-port lock keeps burst beats
//   contiguous on the bank.
//
//   Optional feature macro: SRAM_ARB_STARVE_EN
//     When defined, every port has a wait counter. A port that waits
//     STARVE_LIMIT cycles breaks any held lock and is granted ahead of the
//     round-robin pointer.
//
// Ports
//   clk_i, rst_ni       clock, synchronous active-low reset
//   req_i/we_i/lock_i   per-port request, write enable, hold-grant-after-beat
//   addr_i/be_i/wdata_i per-port packed address, byte enables, write data
//   gnt_o               one-hot combinational grant
//   rvalid_o/rdata_o    one-hot read-data valid, read data (bank passthrough)
//   sram_*_o            registered bank controls
//   sram_rdata_i        bank read data
//
// States
//   state  | meaning
//   ARB    | round-robin arbitration among all requesters
//   LOCKED | only owner_q may be granted; released by owner or idle timeout

module sram_port_arbiter #(
   parameter int NUM_PORTS         = 2,
   parameter int ADDR_WIDTH        = 16,
   parameter int DATA_WIDTH        = 32,
   parameter int SRAM_READ_LATENCY = 2,
   parameter int LOCK_TIMEOUT      = 4,
   parameter int STARVE_LIMIT      = 16
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic [NUM_PORTS-1:0]               req_i,
   input  logic [NUM_PORTS-1:0]               we_i,
   input  logic [NUM_PORTS-1:0]               lock_i,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    addr_i,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]  be_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]    wdata_i,
   output logic [NUM_PORTS-1:0]               gnt_o,
   output logic [NUM_PORTS-1:0]               rvalid_o,
   output logic [DATA_WIDTH-1:0]              rdata_o,
   output logic                               sram_cs_o,
   output logic                               sram_we_o,
   output logic [ADDR_WIDTH-1:0]              sram_addr_o,
   output logic [DATA_WIDTH/8-1:0]            sram_be_o,
   output logic [DATA_WIDTH-1:0]              sram_wdata_o,
   input  logic [DATA_WIDTH-1:0]              sram_rdata_i
);

   localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int BE_W   = DATA_WIDTH / 8;
   localparam int IDLE_W = $clog2(LOCK_TIMEOUT + 1);
   localparam int LAT    = SRAM_READ_LATENCY;

   if (NUM_PORTS < 2 || (DATA_WIDTH % 8) != 0 || SRAM_READ_LATENCY < 1 ||
       LOCK_TIMEOUT < 1 || STARVE_LIMIT < 1) begin : g_param_check
      $error("sram_port_arbiter: illegal parameter combination");
   end

   typedef enum logic {ARB, LOCKED} state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]        owner_q, owner_d;
   logic [IDLE_W-1:0]       idle_q, idle_d;

   logic                    arb_found;
   logic [IDX_W-1:0]        arb_idx;
   logic                    gnt_valid;
   logic [IDX_W-1:0]        gnt_idx;

   logic                    sel_we;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [BE_W-1:0]         sel_be;
   logic [DATA_WIDTH-1:0]   sel_wdata;

   logic [LAT:0]            rd_valid_q;
   logic [LAT:0][IDX_W-1:0] rd_port_q;

   function automatic logic [IDX_W-1:0] ptr_next(input logic [IDX_W-1:0] idx);
      if (int'(idx) == NUM_PORTS - 1) return '0;
      return idx + IDX_W'(1);
   endfunction

   // Returns {found, index} of the first requester at or after ptr.
   function automatic logic [IDX_W:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                              input logic [IDX_W-1:0]     ptr);
      logic             found;
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] cand;
      int               c;
      found = 1'b0;
      idx   = ptr;
      for (int k = 0; k < NUM_PORTS; k++) begin
         c = int'(ptr) + k;
         if (c >= NUM_PORTS) c = c - NUM_PORTS;
         cand = IDX_W'(c);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

`ifdef SRAM_ARB_STARVE_EN
   localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

   logic [NUM_PORTS-1:0][WAIT_W-1:0] wait_q;
   logic [NUM_PORTS-1:0]             starved;

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         starved[p] = (wait_q[p] >= WAIT_W'(STARVE_LIMIT));
      end
   end

   // Counters saturate at the limit so a long wait cannot wrap back to zero.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wait_q <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt_o[p]) begin
               wait_q[p] <= '0;
            end else if (req_i[p] && !starved[p]) begin
               wait_q[p] <= wait_q[p] + WAIT_W'(1);
            end
         end
      end
   end
`endif

   // Round-robin pick; a starved requester overrides it, lowest index first.
   always_comb begin
      {arb_found, arb_idx} = rr_pick(req_i, rr_ptr_q);
`ifdef SRAM_ARB_STARVE_EN
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
         if (starved[p] && req_i[p]) begin
            arb_found = 1'b1;
            arb_idx   = IDX_W'(p);
         end
      end
`endif
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      owner_d   = owner_q;
      idle_d    = idle_q;
      gnt_valid = 1'b0;
      gnt_idx   = rr_ptr_q;
      case (state_q)
         ARB: begin
            if (arb_found) begin
               gnt_valid = 1'b1;
               gnt_idx   = arb_idx;
               rr_ptr_d  = ptr_next(arb_idx);
               if (lock_i[arb_idx]) begin
                  state_d = LOCKED;
                  owner_d = arb_idx;
                  idle_d  = '0;
               end
            end
         end
         LOCKED: begin
            if (req_i[owner_q]) begin
               gnt_valid = 1'b1;
               gnt_idx   = owner_q;
               idle_d    = '0;
               rr_ptr_d  = ptr_next(owner_q);
               if (!lock_i[owner_q]) state_d = ARB;
            end else if (idle_q == IDLE_W'(LOCK_TIMEOUT - 1)) begin
               state_d = ARB;
               idle_d  = '0;
            end else begin
               idle_d = idle_q + IDLE_W'(1);
            end
`ifdef SRAM_ARB_STARVE_EN
            // The owner keeps this cycle's beat; the lock ends after it.
            if (|starved) begin
               state_d = ARB;
               idle_d  = '0;
            end
`endif
         end
         default: state_d = ARB;
      endcase
      if (!rst_ni) gnt_valid = 1'b0;
   end

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         gnt_o[p] = gnt_valid && (gnt_idx == IDX_W'(p));
      end
   end

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_be    = '0;
      sel_wdata = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (gnt_idx == IDX_W'(p)) begin
            sel_we    = we_i[p];
            sel_addr  = addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
            sel_be    = be_i[p*BE_W +: BE_W];
            sel_wdata = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= ARB;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         idle_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         idle_q   <= idle_d;
      end
   end

   // Bank pins: data fields hold their last value when no beat is issued.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sram_cs_o    <= 1'b0;
         sram_we_o    <= 1'b0;
         sram_addr_o  <= '0;
         sram_be_o    <= '0;
         sram_wdata_o <= '0;
      end else begin
         sram_cs_o <= gnt_valid;
         if (gnt_valid) begin
            sram_we_o    <= sel_we;
            sram_addr_o  <= sel_addr;
            sram_be_o    <= sel_be;
            sram_wdata_o <= sel_wdata;
         end
      end
   end

   // Stage 0 is loaded with the grant; stage LAT lines up with bank data.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rd_valid_q <= '0;
         rd_port_q  <= '0;
      end else begin
         rd_valid_q <= {rd_valid_q[LAT-1:0], gnt_valid && !sel_we};
         rd_port_q  <= {rd_port_q[LAT-1:0], gnt_idx};
      end
   end

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         rvalid_o[p] = rd_valid_q[LAT] && (rd_port_q[LAT] == IDX_W'(p));
      end
   end

   assign rdata_o = sram_rdata_i;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
//   Directed-vector bench for sram_port_arbiter (2 ports, 16-bit address,
//   32-bit data, read latency 2, lock timeout 4, starve limit 16).
//   Includes a behavioural bank; the preemption scenario is compiled only
//   when SRAM_ARB_STARVE_EN is defined.

module tb_sram_port_arbiter;

   localparam int LAT = 2;

   logic        clk_sys = 1'b0;
   logic        rst_b;
   logic [1:0]  req, we, lock;
   logic [31:0] addr;
   logic [7:0]  be;
   logic [63:0] wdata;
   logic [1:0]  gnt, rvalid;
   logic [31:0] rdata;
   logic        sram_cs, sram_we;
   logic [15:0] sram_addr;
   logic [3:0]  sram_be;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;

   always #5 clk_sys = ~clk_sys;

   sram_port_arbiter #(
      .NUM_PORTS(2), .ADDR_WIDTH(16), .DATA_WIDTH(32),
      .SRAM_READ_LATENCY(LAT), .LOCK_TIMEOUT(4), .STARVE_LIMIT(16)
   ) dut (
      .clk_i(clk_sys), .rst_ni(rst_b),
      .req_i(req), .we_i(we), .lock_i(lock),
      .addr_i(addr), .be_i(be), .wdata_i(wdata),
      .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
      .sram_cs_o(sram_cs), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
      .sram_be_o(sram_be), .sram_wdata_o(sram_wdata),
      .sram_rdata_i(sram_rdata)
   );

   // behavioural bank, two-cycle read latency
   logic [31:0] mem [0:255];
   logic [31:0] rd_s1, rd_s2;

   always @(posedge clk_sys) begin
      if (sram_cs && sram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (sram_be[b]) mem[sram_addr[7:0]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
         end
      end
      rd_s1 <= (sram_cs && !sram_we) ? mem[sram_addr[7:0]] : 32'h0;
      rd_s2 <= rd_s1;
   end
   assign sram_rdata = rd_s2;

   // expectation model
   logic [31:0] exp_mem [0:255];
   logic        ev [0:LAT];
   logic [31:0] ed [0:LAT];
   logic [1:0]  ep [0:LAT];
   logic        prev_cs, prev_we, zero_chk;
   logic [15:0] prev_addr;
   logic [31:0] prev_wdata;
   logic [15:0] pa [0:1];
   logic [31:0] pd [0:1];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, check at the falling edge, advance model.
   task automatic cyc(input string tag, input logic r, input logic [1:0] rq,
                      input logic [1:0] w, input logic [1:0] lk, input logic [1:0] eg);
      logic pi;
      rst_b = r;
      req   = rq;
      we    = w;
      lock  = lk;
      addr  = {pa[1], pa[0]};
      wdata = {pd[1], pd[0]};
      be    = 8'hFF;
      @(negedge clk_sys);
      check_val({tag, "_gnt"}, 64'(gnt), 64'(eg));
      check_val({tag, "_rvalid"}, 64'(rvalid), 64'(ev[LAT] ? ep[LAT] : 2'b00));
      if (ev[LAT]) check_val({tag, "_rdata"}, 64'(rdata), 64'(ed[LAT]));
      check_val({tag, "_cs"}, 64'(sram_cs), 64'(prev_cs));
      if (prev_cs) begin
         check_val({tag, "_we"}, 64'(sram_we), 64'(prev_we));
         check_val({tag, "_addr"}, 64'(sram_addr), 64'(prev_addr));
         if (prev_we) check_val({tag, "_wdata"}, 64'(sram_wdata), 64'(prev_wdata));
      end
      if (zero_chk) begin
         check_val({tag, "_rst_we"}, 64'(sram_we), 64'h0);
         check_val({tag, "_rst_addr"}, 64'(sram_addr), 64'h0);
         check_val({tag, "_rst_be"}, 64'(sram_be), 64'h0);
         check_val({tag, "_rst_wdata"}, 64'(sram_wdata), 64'h0);
      end
      for (int k = LAT; k > 0; k--) begin
         ev[k] = ev[k-1];
         ed[k] = ed[k-1];
         ep[k] = ep[k-1];
      end
      ev[0] = 1'b0;
      ed[0] = 32'h0;
      ep[0] = eg;
      if (eg != 2'b00) begin
         pi = eg[1];
         if (w[pi]) begin
            exp_mem[pa[pi][7:0]] = pd[pi];
         end else begin
            ev[0] = 1'b1;
            ed[0] = exp_mem[pa[pi][7:0]];
         end
         prev_cs    = 1'b1;
         prev_we    = w[pi];
         prev_addr  = pa[pi];
         prev_wdata = pd[pi];
      end else begin
         prev_cs = 1'b0;
      end
      if (!r) begin
         for (int k = 0; k <= LAT; k++) ev[k] = 1'b0;
         prev_cs  = 1'b0;
         zero_chk = 1'b1;
      end else begin
         zero_chk = 1'b0;
      end
      @(posedge clk_sys);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc("idle", 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = {24'hC0FFEE, 8'(i)};
         exp_mem[i] = {24'hC0FFEE, 8'(i)};
      end
      for (int k = 0; k <= LAT; k++) begin
         ev[k] = 1'b0; ed[k] = 32'h0; ep[k] = 2'b00;
      end
      prev_cs = 1'b0; prev_we = 1'b0; prev_addr = '0; prev_wdata = '0;
      zero_chk = 1'b0;
      pa[0] = 16'h0011; pa[1] = 16'h0022;
      pd[0] = 32'h1111_0000; pd[1] = 32'h2222_0000;
      rst_b = 1'b0; req = '0; we = '0; lock = '0;
      addr = '0; be = '0; wdata = '0;
      repeat (2) @(posedge clk_sys);
      #1;

      // reset held with requests pending: no grant, outputs cleared
      cyc("rst", 1'b0, 2'b11, 2'b00, 2'b00, 2'b00);

      // continuous reads alternate 0,1,0,1 with rvalid three cycles later
      cyc("alt0", 1'b1, 2'b11, 2'b00, 2'b00, 2'b01);
      cyc("alt1", 1'b1, 2'b11, 2'b00, 2'b00, 2'b10);
      cyc("alt2", 1'b1, 2'b11, 2'b00, 2'b00, 2'b01);
      cyc("alt3", 1'b1, 2'b11, 2'b00, 2'b00, 2'b10);
      cyc("alt4", 1'b1, 2'b11, 2'b00, 2'b00, 2'b01);
      cyc("alt5", 1'b1, 2'b11, 2'b00, 2'b00, 2'b10);
      idle(4);

      // write from port 1 then read-back from port 0 on the next cycle
      pa[0] = 16'h0010; pa[1] = 16'h0010;
      pd[0] = 32'h0;    pd[1] = 32'hDEADBEEF;
      cyc("wr", 1'b1, 2'b10, 2'b10, 2'b00, 2'b10);
      cyc("rd", 1'b1, 2'b01, 2'b00, 2'b00, 2'b01);
      cyc("rd_wait1", 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
      cyc("rd_wait2", 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
      @(negedge clk_sys);
      check_val("rd_back_rvalid", 64'(rvalid), 64'h1);
      check_val("rd_back_data", 64'(rdata), 64'hDEADBEEF);
      @(posedge clk_sys);
      #1;
      for (int k = 0; k <= LAT; k++) ev[k] = 1'b0;
      prev_cs = 1'b0;
      idle(2);

      // bring pointer back to port 0, then a 4-beat locked burst
      pa[0] = 16'h0031; pa[1] = 16'h0032;
      cyc("pre", 1'b1, 2'b10, 2'b00, 2'b00, 2'b10);
      cyc("lk0", 1'b1, 2'b11, 2'b00, 2'b01, 2'b01);
      cyc("lk1", 1'b1, 2'b11, 2'b00, 2'b01, 2'b01);
      cyc("lk2", 1'b1, 2'b11, 2'b00, 2'b01, 2'b01);
      cyc("lk3", 1'b1, 2'b11, 2'b00, 2'b00, 2'b01);
      cyc("lk4", 1'b1, 2'b11, 2'b00, 2'b00, 2'b10);
      idle(4);

      // owner locks then goes idle: lock times out after four idle cycles
      cyc("to0", 1'b1, 2'b11, 2'b00, 2'b01, 2'b01);
      cyc("to1", 1'b1, 2'b10, 2'b00, 2'b00, 2'b00);
      cyc("to2", 1'b1, 2'b10, 2'b00, 2'b00, 2'b00);
      cyc("to3", 1'b1, 2'b10, 2'b00, 2'b00, 2'b00);
      cyc("to4", 1'b1, 2'b10, 2'b00, 2'b00, 2'b00);
      cyc("to5", 1'b1, 2'b10, 2'b00, 2'b00, 2'b10);
      // pointer wrapped from port 1 back to port 0
      cyc("wrap", 1'b1, 2'b11, 2'b00, 2'b00, 2'b01);
      idle(4);

      // reset while two reads are in flight and port 0 holds a lock
      cyc("rf0", 1'b1, 2'b11, 2'b00, 2'b00, 2'b10);
      cyc("rf1", 1'b1, 2'b11, 2'b00, 2'b01, 2'b01);
      cyc("rfr", 1'b0, 2'b11, 2'b00, 2'b00, 2'b00);
      cyc("post1", 1'b1, 2'b10, 2'b00, 2'b00, 2'b10);
      cyc("post2", 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
      idle(4);

`ifdef SRAM_ARB_STARVE_EN
      // port 0 never releases; port 1 is granted after 17 cycles of waiting
      cyc("sv0", 1'b1, 2'b11, 2'b00, 2'b01, 2'b01);
      for (int k = 1; k <= 16; k++) cyc("sv_hold", 1'b1, 2'b11, 2'b00, 2'b01, 2'b01);
      cyc("sv17", 1'b1, 2'b11, 2'b00, 2'b01, 2'b10);
      cyc("sv18", 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
      idle(4);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
